ram_fifo_sync: RTL
==================

// Module: ram_fifo_sync
// PURPOSE
//  Parametrised single-clock synchronous FIFO built on a simple dual-port RAM array.
//  Adds occupancy tracking, full/empty and almost flags, overflow/underflow detection and a registered read port with valid.
//  Sits between producer and consumer datapaths in the same clock domain; replaces ad-hoc RAM plus pointer logic.
// PARAMETERS
//  DATA_WIDTH          8    word width in bits
//  ADDR_WIDTH          6    RAM address width; DEPTH = 2**ADDR_WIDTH (64)
//  ALMOST_FULL_LEVEL   60   almost_full asserted when count >= this value
//  ALMOST_EMPTY_LEVEL  4    almost_empty asserted when count <= this value
// PORTS
//  clk           in   1               single clock, rising edge
//  rst           in   1               asynchronous reset, active-high
//  wr_en         in   1               write request
//  wr_data       in   DATA_WIDTH      write word
//  rd_en         in   1               read request
//  rd_data       out  DATA_WIDTH      registered read word
//  rd_valid      out  1               rd_data holds a newly popped word this cycle
//  full          out  1               count == DEPTH
//  empty         out  1               count == 0
//  almost_full   out  1               count >= ALMOST_FULL_LEVEL
//  almost_empty  out  1               count <= ALMOST_EMPTY_LEVEL
//  count         out  ADDR_WIDTH+1    current occupancy, 0..DEPTH
//  overflow      out  1               1-cycle pulse: wr_en while full and write rejected
//  underflow     out  1               1-cycle pulse: rd_en while empty
// BEHAVIOUR
//  - One clock, clk; reset rst is asynchronous and active-high.
//  - Reset values: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
//    Flags at reset: empty=1, almost_empty=1, full=0, almost_full=0.
//  - RAM contents are not cleared by reset.
//  - Pointers are ADDR_WIDTH+1 bits. The low bits address the RAM; the MSB is a wrap bit.
//    Both pointers increment modulo 2**(ADDR_WIDTH+1).
//  - Write accept: wr_acc = wr_en & ~full. ram[wr_ptr] <= wr_data at the edge, then wr_ptr++.
//  - Read accept: rd_acc = rd_en & ~empty. rd_data <= ram[rd_ptr] at the edge, then rd_ptr++, and rd_valid=1 next cycle.
//  - Read latency is one cycle. rd_valid is otherwise 0, and rd_data holds its last value.
//  - count: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
//  - All flags decode combinationally from the registered count. They update the cycle after an accepted operation.
//  - Simultaneous wr_en and rd_en:
//    - Full: read accepted, write rejected, overflow=1; count goes DEPTH -> DEPTH-1.
//    - Empty: write accepted, read rejected, underflow=1; count goes 0 -> 1. No bypass; the word is readable next cycle.
//    - Otherwise: both accepted.
//  - overflow and underflow are registered single-cycle pulses, re-evaluated every cycle.
//  - Reset mid-operation: in-flight rd_valid drops immediately and the FIFO is logically empty. Stale RAM data is never presented as valid.
// CONFIGURATION
//  - Macro RAM_FIFO_PARITY_EN.
//  - When defined:
//    - Each RAM word is DATA_WIDTH+1 bits; the extra bit is the even parity of wr_data, computed at write.
//    - On every accepted read, parity is rechecked.
//    - Extra output parity_err (out, 1) is asserted with rd_valid when the stored word fails the check.
//    - parity_err resets to 0.
//  - When undefined: RAM is DATA_WIDTH bits; the parity_err port and logic do not exist.
// STRUCTURE
//  - Shared package ram_fifo_pkg holds:
//    - DEPTH = 1<<ADDR_WIDTH;
//    - PTR_WIDTH = ADDR_WIDTH+1;
//    - the parity helper function;
//    - default level constants.
//  - Sub-module ram_sdp_sync: a single-clock simple dual-port RAM.
//    - Write port: we/waddr/wdata.
//    - Registered read port: re/raddr/rdata.
//    - Parameters: WIDTH, ADDR_WIDTH.
//  - The top level holds the pointers, count, flags and pulses.
// TESTING
//  - Reset then idle: empty=1, almost_empty=1, count=0, rd_valid=0, full=0.
//  - Write 0x00..0x3F (64 words): count 64, full=1, almost_full=1 once count reaches 60.
//    A 65th write gives overflow=1 for one cycle with count still 64.
//  - Read all 64 words: rd_data = 0x00..0x3F in order, each with rd_valid one cycle after rd_en; empty=1 afterwards.
//    A further rd_en gives underflow=1 and rd_valid=0.
//  - Steady stream: fill to 10, then wr_en=rd_en=1 for 200 cycles. count stays 10 and data order is preserved across pointer wrap (ptr MSB toggles).
//  - Simultaneous wr_en and rd_en at full: count 64 -> 63, overflow=1.
//    Simultaneous wr_en and rd_en at empty: count 0 -> 1, underflow=1, rd_valid=0.
//  - Assert rst with 20 words held and a read in flight: rd_valid drops the same cycle, count=0, empty=1.
//    Next write of 0xA5 followed by a read returns 0xA5.
//    With RAM_FIFO_PARITY_EN, force a stored parity bit flip: parity_err=1 coincident with rd_valid.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ram_fifo_pkg
// Shared constants, types and helpers for the ram_fifo_sync FIFO.
//   DEPTH / PTR_WIDTH   geometry derived from the default address width
//   *_DEF               default parameter values for the FIFO top level
//   fifo_op_e           accepted-operation encoding {read, write}
//   even_parity()       even parity bit of a (zero-extended) data word
// Optional feature macro used by the FIFO: RAM_FIFO_PARITY_EN.
// ---------------------------------------------------------------------------
package ram_fifo_pkg;

  localparam int DATA_WIDTH_DEF         = 8;
  localparam int ADDR_WIDTH_DEF         = 6;
  localparam int DEPTH                  = 1 << ADDR_WIDTH_DEF;
  localparam int PTR_WIDTH              = ADDR_WIDTH_DEF + 1;
  localparam int ALMOST_FULL_LEVEL_DEF  = 60;
  localparam int ALMOST_EMPTY_LEVEL_DEF = 4;

  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int PARITY_MAX_W = 64;

  // Operations actually accepted this cycle, packed as {rd_acc, wr_acc}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_fifo_sync_ram.sv
// ---------------------------------------------------------------------------
// ram_sdp_sync
// Single-clock simple dual-port RAM with a registered read port.
//   clk    in   clock, rising edge
//   rst    in   async active-high reset; clears only the read register
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write word
//   re     in   read enable; rdata loads mem[raddr] at the edge
//   raddr  in   read address
//   rdata  out  registered read word, holds when re is low
// The array itself is never reset.
// ---------------------------------------------------------------------------
module ram_sdp_sync #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_fifo_sync.sv
// ---------------------------------------------------------------------------
// ram_fifo_sync
// Single-clock synchronous FIFO on a simple dual-port RAM, with occupancy,
// full/empty/almost flags, overflow/underflow pulses and a registered read
// port with valid (one cycle read latency).
//   clk           in   clock, rising edge
//   rst           in   asynchronous reset, active-high
//   wr_en         in   write request (ignored while full)
//   wr_data       in   write word
//   rd_en         in   read request (ignored while empty)
//   rd_data       out  registered read word, holds between reads
//   rd_valid      out  rd_data carries a freshly popped word
//   full / empty  out  count == DEPTH / count == 0
//   almost_full   out  count >= ALMOST_FULL_LEVEL
//   almost_empty  out  count <= ALMOST_EMPTY_LEVEL
//   count         out  occupancy 0..DEPTH
//   overflow      out  1-cycle pulse: write requested while full
//   underflow     out  1-cycle pulse: read requested while empty
//   parity_err    out  (RAM_FIFO_PARITY_EN only) popped word failed parity,
//                      coincident with rd_valid
// Optional feature macro: RAM_FIFO_PARITY_EN stores an even parity bit with
// every word and rechecks it on each pop.
// ---------------------------------------------------------------------------
module ram_fifo_sync
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH         = ADDR_WIDTH_DEF,
  parameter int ALMOST_FULL_LEVEL  = ALMOST_FULL_LEVEL_DEF,
  parameter int ALMOST_EMPTY_LEVEL = ALMOST_EMPTY_LEVEL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
`ifdef RAM_FIFO_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int PTR_W = ADDR_WIDTH + 1;
`ifdef RAM_FIFO_PARITY_EN
  localparam int RAM_W = DATA_WIDTH + 1;
`else
  localparam int RAM_W = DATA_WIDTH;
`endif

  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(1 << ADDR_WIDTH);
  localparam logic [PTR_W-1:0] AF_LVL   = PTR_W'(ALMOST_FULL_LEVEL);
  localparam logic [PTR_W-1:0] AE_LVL   = PTR_W'(ALMOST_EMPTY_LEVEL);

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic             rd_valid_d, rd_valid_q;
  logic             overflow_d, overflow_q;
  logic             underflow_d, underflow_q;

  logic             wr_acc;
  logic             rd_acc;
  fifo_op_e         op;
  logic [RAM_W-1:0] ram_wdata;
  logic [RAM_W-1:0] ram_rdata;

  // Occupancy is the pointer distance. The extra wrap bit is what lets a
  // distance of DEPTH (full) differ from a distance of 0 (empty); the modulo
  // subtraction stays correct across pointer wrap.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // At full a simultaneous read still drains, at empty a simultaneous write
  // still fills; the rejected side raises its error pulse.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;
  assign op     = fifo_op_e'({rd_acc, wr_acc});

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_valid_d  = rd_acc;
    overflow_d  = wr_en & full;
    underflow_d = rd_en & empty;
    case (op)
      OP_WR:   wr_ptr_d = wr_ptr_q + 1'b1;
      OP_RD:   rd_ptr_d = rd_ptr_q + 1'b1;
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef RAM_FIFO_PARITY_EN
  assign ram_wdata  = {even_parity(PARITY_MAX_W'(wr_data)), wr_data};
  assign rd_data    = ram_rdata[DATA_WIDTH-1:0];
  // A good stored word has even overall parity, so any odd XOR is an error.
  assign parity_err = rd_valid_q & (^ram_rdata);
`else
  assign ram_wdata  = wr_data;
  assign rd_data    = ram_rdata;
`endif

  // Read and write never hit the same address in one cycle: equal addresses
  // mean empty (read blocked) or full (write blocked).
  ram_sdp_sync #(
    .WIDTH      (RAM_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (ram_wdata),
    .re    (rd_acc),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

endmodule
